// File: rtl/fcc_rx.sv
// fcc_rx: router input buffer that returns one upstream credit per drained flit
// and flags head/tail framing violations on arrival.
module fcc_rx #(
  parameter int FLIT_W = 34,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flit_in_valid,
  input  logic [FLIT_W-1:0] flit_in,
  output logic              credit_out,
  output logic              flit_out_valid,
  output logic [FLIT_W-1:0] flit_out,
  input  logic              flit_out_ready,
  output logic [CNT_W-1:0]  occupancy,
  output logic              overflow_err,
  output logic              frame_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [0:0]        state_q, state_d;
  logic              credit_q, credit_d, ovf_q, ovf_d, ferr_q, ferr_d;
  logic              deq, enq, head, tail;
  always_comb begin
    deq      = (occ_q != '0) && flit_out_ready;
    enq      = flit_in_valid && ((occ_q != CNT_W'(DEPTH)) || deq);
    head     = flit_in[FLIT_W-1];
    tail     = flit_in[FLIT_W-2];
    wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d    = (enq && !deq) ? occ_q + CNT_W'(1) :
               (deq && !enq) ? occ_q - CNT_W'(1) : occ_q;
    credit_d = deq;
    ovf_d    = ovf_q || (flit_in_valid && !enq);
    // A head inside a packet, or a non-head outside one, is a violation.
    ferr_d   = ferr_q || (flit_in_valid && (head == (state_q == IN_PKT)));
    state_d  = !flit_in_valid ? state_q :
               (head || state_q == IN_PKT) ? (tail ? IDLE : IN_PKT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= IDLE;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      state_q  <= state_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= flit_in;
  end
  assign flit_out       = mem_q[rd_ptr_q];
  assign flit_out_valid = occ_q != '0;
  assign occupancy      = occ_q;
  assign credit_out     = credit_q;
  assign overflow_err   = ovf_q;
  assign frame_err      = ferr_q;
endmodule

// File: tb/tb_fcc_rx.sv
// tb_fcc_rx: scoreboard bench for fcc_rx; expected flits queued at drive time,
// dequeued flits collected and compared in order by each scenario task.
module tb_fcc_rx;
  localparam int W  = 34;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flit_in_valid = 1'b0;
  logic [W-1:0]  flit_in = '0;
  logic          flit_out_ready = 1'b0;
  logic          credit_out, flit_out_valid, overflow_err, frame_err;
  logic [W-1:0]  flit_out;
  logic [CW-1:0] occupancy;
  int passed = 0, total = 0;
  int m_occ = 0, credits = 0, deqs = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  fcc_rx #(.FLIT_W(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flit_in_valid(flit_in_valid), .flit_in(flit_in),
    .credit_out(credit_out), .flit_out_valid(flit_out_valid), .flit_out(flit_out),
    .flit_out_ready(flit_out_ready), .occupancy(occupancy),
    .overflow_err(overflow_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle; the model decides acceptance, the DUT's dequeued flits are collected.
  task automatic step(input logic v, input logic [W-1:0] f, input logic r);
    logic mdeq;
    flit_in_valid = v; flit_in = f; flit_out_ready = r;
    #1;
    if (flit_out_valid && flit_out_ready) got_q.push_back(flit_out);
    mdeq = (m_occ > 0) && r;
    if (v && (m_occ < D || mdeq)) begin
      exp_q.push_back(f);
      m_occ++;
    end
    if (mdeq) begin
      m_occ--;
      deqs++;
    end
    @(posedge clk); #1;
    if (credit_out) credits++;
    flit_in_valid = 1'b0; flit_out_ready = 1'b0;
  endtask

  task automatic pulse_rst();
    flit_in_valid = 1'b0; flit_out_ready = 1'b0;
    rst = 1'b1; #3; rst = 1'b0;
    exp_q.delete(); got_q.delete();
    m_occ = 0; credits = 0; deqs = 0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (occupancy !== '0) $display("FAIL rst_occ got %0d want 0", occupancy); else passed++;
    total++; if (flit_out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", flit_out_valid); else passed++;
    total++; if (credit_out !== 1'b0) $display("FAIL rst_credit got %b want 0", credit_out); else passed++;
    total++; if (overflow_err !== 1'b0) $display("FAIL rst_ovf got %b want 0", overflow_err); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL rst_ferr got %b want 0", frame_err); else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 34'h0_0000_00A1, 1'b0);
    step(1'b1, 34'h0_0000_00A2, 1'b0);
    step(1'b1, 34'h0_0000_00A3, 1'b0);
    step(1'b1, 34'h0_0000_00A4, 1'b0);
    step(1'b0, '0, 1'b1);
    total++; if (frame_err !== 1'b1) $display("FAIL pre_ferr got %b want 1", frame_err); else passed++;
    total++; if (occupancy !== 3) $display("FAIL pre_occ got %0d want 3", occupancy); else passed++;
    total++; if (credit_out !== 1'b1) $display("FAIL pre_credit got %b want 1", credit_out); else passed++;
    rst = 1'b1; #1;
    total++; if (occupancy !== '0) $display("FAIL mid_occ got %0d want 0", occupancy); else passed++;
    total++; if (flit_out_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", flit_out_valid); else passed++;
    total++; if (credit_out !== 1'b0) $display("FAIL mid_credit got %b want 0", credit_out); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL mid_ferr got %b want 0", frame_err); else passed++;
    total++; if (overflow_err !== 1'b0) $display("FAIL mid_ovf got %b want 0", overflow_err); else passed++;
    #2; rst = 1'b0;
    exp_q.delete(); got_q.delete();
    m_occ = 0; credits = 0; deqs = 0;
    repeat (4) step(1'b0, '0, 1'b1);
    total++; if (credits !== 0) $display("FAIL post_rst_credits got %0d want 0", credits); else passed++;
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] f [4];
    f = '{34'h2_0000_0001, 34'h0_0000_0002, 34'h0_0000_0003, 34'h1_0000_0004};
    pulse_rst();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, f[i], 1'b0);
      total++; if (credit_out !== 1'b0) $display("FAIL fill_credit%0d got %b want 0", i, credit_out); else passed++;
    end
    total++; if (occupancy !== 4) $display("FAIL fill_occ got %0d want 4", occupancy); else passed++;
    total++; if (flit_out !== f[0]) $display("FAIL fill_head got %h want %h", flit_out, f[0]); else passed++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1);
      total++; if (credit_out !== 1'b1) $display("FAIL drain_credit%0d got %b want 1", i, credit_out); else passed++;
    end
    step(1'b0, '0, 1'b0);
    total++; if (credit_out !== 1'b0) $display("FAIL drain_credit_end got %b want 0", credit_out); else passed++;
    total++; if (credits !== deqs) $display("FAIL drain_credits got %0d want %0d", credits, deqs); else passed++;
    total++; if (got_q.size() != exp_q.size()) $display("FAIL fd_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      total++; if (got_q[0] !== exp_q[0]) $display("FAIL fd_order got %h want %h", got_q[0], exp_q[0]); else passed++;
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
  endtask

  task automatic test_overflow();
    pulse_rst();
    step(1'b1, 34'h2_0000_0011, 1'b0);
    step(1'b1, 34'h0_0000_0012, 1'b0);
    step(1'b1, 34'h0_0000_0013, 1'b0);
    step(1'b1, 34'h1_0000_0014, 1'b0);
    step(1'b1, 34'h3_0000_DEAD, 1'b0);
    total++; if (occupancy !== 4) $display("FAIL ovf_occ got %0d want 4", occupancy); else passed++;
    total++; if (overflow_err !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow_err); else passed++;
    repeat (4) step(1'b0, '0, 1'b1);
    total++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow_err); else passed++;
    total++; if (flit_out_valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", flit_out_valid); else passed++;
    total++; if (got_q.size() != exp_q.size()) $display("FAIL ovf_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      total++; if (got_q[0] !== exp_q[0]) $display("FAIL ovf_order got %h want %h", got_q[0], exp_q[0]); else passed++;
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
  endtask

  task automatic test_full_simul();
    pulse_rst();
    step(1'b1, 34'h2_0000_0021, 1'b0);
    step(1'b1, 34'h0_0000_0022, 1'b0);
    step(1'b1, 34'h0_0000_0023, 1'b0);
    step(1'b1, 34'h1_0000_0024, 1'b0);
    step(1'b1, 34'h3_0000_0055, 1'b1);
    total++; if (occupancy !== 4) $display("FAIL simul_occ got %0d want 4", occupancy); else passed++;
    total++; if (overflow_err !== 1'b0) $display("FAIL simul_ovf got %b want 0", overflow_err); else passed++;
    total++; if (credit_out !== 1'b1) $display("FAIL simul_credit got %b want 1", credit_out); else passed++;
    step(1'b0, '0, 1'b0);
    total++; if (credit_out !== 1'b0) $display("FAIL simul_credit_once got %b want 0", credit_out); else passed++;
    repeat (4) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    total++; if (credits !== 5) $display("FAIL simul_credits got %0d want 5", credits); else passed++;
    total++; if (got_q.size() != exp_q.size()) $display("FAIL simul_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      total++; if (got_q[0] !== exp_q[0]) $display("FAIL simul_order got %h want %h", got_q[0], exp_q[0]); else passed++;
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] f;
    pulse_rst();
    for (int i = 0; i < 10; i++) begin
      f = {2'b11, 32'(i * 32'h111 + 7)};
      step(1'b1, f, 1'b1);
      total++; if (!(flit_out_valid === 1'b1 && flit_out === f)) $display("FAIL pass_flit%0d got %h want %h", i, flit_out, f); else passed++;
      total++; if (occupancy !== 1) $display("FAIL pass_occ%0d got %0d want 1", i, occupancy); else passed++;
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    total++; if (occupancy !== 0) $display("FAIL pass_occ_end got %0d want 0", occupancy); else passed++;
    total++; if (credits !== 10) $display("FAIL pass_credits got %0d want 10", credits); else passed++;
    total++; if (got_q.size() != exp_q.size()) $display("FAIL pass_count got %0d want %0d", got_q.size(), exp_q.size()); else passed++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      total++; if (got_q[0] !== exp_q[0]) $display("FAIL pass_order got %h want %h", got_q[0], exp_q[0]); else passed++;
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
  endtask

  task automatic test_framing();
    logic [W-1:0] f [5];
    f = '{34'h3_0000_0031, 34'h2_0000_0032, 34'h0_0000_0033, 34'h1_0000_0034, 34'h3_0000_0035};
    pulse_rst();
    step(1'b1, 34'h0_0000_0BAD, 1'b1);
    total++; if (frame_err !== 1'b1) $display("FAIL frame_body_idle got %b want 1", frame_err); else passed++;
    pulse_rst();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, f[i], 1'b1);
      total++; if (frame_err !== 1'b0) $display("FAIL frame_ok%0d got %b want 0", i, frame_err); else passed++;
    end
    step(1'b1, 34'h1_0000_0036, 1'b1);
    total++; if (frame_err !== 1'b1) $display("FAIL frame_tail_idle got %b want 1", frame_err); else passed++;
    total++; if (overflow_err !== 1'b0) $display("FAIL frame_ovf got %b want 0", overflow_err); else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_simul();
    test_back_to_back();
    test_framing();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fcc_rx.md
Name: fcc_rx

Overview:
- Receive-side counterpart of the NoC flow-control credit block (fcc).
- Sits at a router input port and buffers incoming flits in a small FIFO.
- Presents buffered flits to the local switch allocator.
- Returns one credit pulse upstream per flit drained, so the sender's fcc credit counter stays consistent with free buffer slots.
- Also checks packet framing (head/tail) on arrival.

Parameters:
- FLIT_W, 34, flit width in bits; bit FLIT_W-1 = head, bit FLIT_W-2 = tail, remaining bits are payload.
- DEPTH, 4, FIFO entries; equals the credit count the upstream fcc initialises to. Power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flit_in_valid  input  1  upstream flit present this cycle; no ready, because credits guarantee space.
- flit_in  input  FLIT_W  incoming flit.
- credit_out  output  1  one-cycle pulse returning one credit upstream.
- flit_out_valid  output  1  FIFO non-empty.
- flit_out  output  FLIT_W  head-of-FIFO flit (first-word fall-through).
- flit_out_ready  input  1  allocator consumes flit_out this cycle.
- occupancy  output  CNT_W  entries currently stored.
- overflow_err  output  1  sticky: a flit was dropped for lack of space.
- frame_err  output  1  sticky: head/tail sequence violation seen.

Behaviour:
- Reset (async assert, sync deassert by the system) drives the following, with no pending credit pulse surviving reset:
  - credit_out=0, flit_out_valid=0, occupancy=0;
  - overflow_err=0, frame_err=0;
  - framing FSM to IDLE;
  - read and write pointers to 0.
- Upstream fcc is reset on the same rst; reset mid-packet discards all buffered flits and no credits are returned for them.
- Enqueue: flit_in_valid=1 writes flit_in at the write pointer when (occupancy<DEPTH) or a dequeue occurs the same cycle.
- Enqueue with occupancy==DEPTH and no same-cycle dequeue:
  - the flit is dropped;
  - overflow_err sets and holds until rst;
  - occupancy is unchanged.
- Dequeue: flit_out_valid && flit_out_ready advances the read pointer. flit_out_ready while empty is ignored.
- flit_out is combinational from the FIFO head entry; it is don't-care when flit_out_valid=0.
- Latency: a flit written at edge N is visible on flit_out with flit_out_valid=1 after edge N (zero bubble when the FIFO was empty).
- Occupancy rules:
  - enqueue only: +1;
  - dequeue only: -1;
  - both, or neither: unchanged.
- Pointers wrap modulo DEPTH.
- Credit return:
  - credit_out is a registered copy of the dequeue strobe, high the cycle after each dequeue;
  - back-to-back dequeues give credit_out high for consecutive cycles;
  - total credit pulses always equal total flits dequeued.
- Framing FSM, evaluated on every flit_in_valid cycle, including dropped flits:
  - IDLE: head=1,tail=1 stays IDLE (single-flit packet).
  - IDLE: head=1,tail=0 goes to IN_PKT.
  - IDLE: head=0 sets frame_err and stays IDLE.
  - IN_PKT: head=1 sets frame_err; treated as a new packet start, so it stays IN_PKT, or goes to IDLE if tail=1.
  - IN_PKT: head=0,tail=0 stays IN_PKT.
  - IN_PKT: head=0,tail=1 goes to IDLE.
- Framing errors never block or drop flits; they are only flagged.
- frame_err and overflow_err clear only on rst.

Test Plan:
- Reset: assert rst mid-run with 3 flits buffered -> immediately occupancy=0, flit_out_valid=0, credit_out=0, both errors 0; no credit pulses follow deassertion.
- Fill and drain (DEPTH=4):
  - send 4 flits 0x2_0000_0001..0x1_0000_0004 (head..tail) with ready=0 -> occupancy=4, credit_out stays 0;
  - then hold ready=1 -> flits emerge in order on 4 consecutive cycles, credit_out high for exactly 4 consecutive cycles starting one cycle after the first dequeue.
- Overflow: with occupancy=4 and ready=0, send a 5th flit -> occupancy stays 4, overflow_err=1 and remains 1 after a full drain; the dropped flit never appears on flit_out.
- Full with simultaneous enqueue and dequeue: occupancy=4, ready=1, flit_in_valid=1 -> flit accepted, occupancy stays 4, overflow_err=0, one credit pulse next cycle.
- Pass-through: empty FIFO, ready held 1, stream of 10 flits one per cycle -> each flit on flit_out the cycle after entry, occupancy oscillates 0/1 without exceeding 1, exactly 10 credit pulses.
- Framing:
  - body flit (head=0,tail=0) in IDLE -> frame_err=1;
  - on a fresh reset, single head+tail flit followed by head, body, tail -> frame_err stays 0 and the FSM ends in IDLE.
